dcache_mem_responder: RTL and testbench

- Memory-side responder for the dcache↔mem request interface. It accepts dcache_mem_req, returns mem_dcache_addrOK and mem_dcache_dataOK, and drives din_mem_dcache.
- Read misses are served as a full-line refill, assembled from single-word beats on a word-granular backing port.
- Writes are write-through single words with a byte strobe, forwarded to the backing port.
- Sits between Dcache and the memory/bus bridge. Only one transaction is in flight at a time.

---
 rtl/dcache_mem_responder.sv | 134 +++++++++++++
 tb/tb_dcache_mem_responder.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_mem_responder.sv
// Memory-side responder for Dcache: line refills built from word beats on a backing port, plus write-through words.
// Optional macro DCACHE_RESP_CRITICAL_FIRST_EN: refill starts at the requested word and wraps around the line.
module dcache_mem_responder #(
    parameter int offset_width = 2,
    parameter int ADDR_W       = 32,
    localparam int LINE_WORDS  = 2 << offset_width,
    localparam int CNT_W       = offset_width + 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [ADDR_W-1:0]          addr_dcache_mem,
    input  logic [31:0]                dout_dcache_mem,
    input  logic                       dcache_mem_req,
    input  logic                       dcache_mem_wr,
    input  logic [1:0]                 dcache_mem_size,
    input  logic [3:0]                 dcache_mem_wstrb,
    output logic                       mem_dcache_addrOK,
    output logic                       mem_dcache_dataOK,
    output logic [32*LINE_WORDS-1:0]   din_mem_dcache,
    output logic                       bk_req,
    output logic                       bk_we,
    output logic [ADDR_W-1:0]          bk_addr,
    output logic [31:0]                bk_wdata,
    output logic [3:0]                 bk_wstrb,
    input  logic                       bk_gnt,
    input  logic                       bk_rvalid,
    input  logic [31:0]                bk_rdata
);
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] WR_ISSUE = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;

    logic [2:0]                    state;
    logic [CNT_W-1:0]              cnt, cnt_nxt, start_d, start_w;
    logic [ADDR_W-1:2]             addr_q;
    logic [31:0]                   data_q;
    logic [3:0]                    strb_q, strb_d;
    logic [LINE_WORDS-1:0][31:0]   line_q;
    logic                          accept;

    assign accept  = rstn && (state == IDLE) && dcache_mem_req;
    assign cnt_nxt = cnt + CNT_W'(1);

    // An all-zero strobe means the byte lanes come from size and the low address bits.
    always_comb begin
        strb_d = dcache_mem_wstrb;
        if (dcache_mem_wstrb == 4'b0000) begin
            case (dcache_mem_size)
                2'd0:    strb_d = 4'b0001 << addr_dcache_mem[1:0];
                2'd1:    strb_d = 4'b0011 << {addr_dcache_mem[1], 1'b0};
                default: strb_d = 4'b1111;
            endcase
        end
    end

`ifdef DCACHE_RESP_CRITICAL_FIRST_EN
    logic [CNT_W-1:0] start_q;
    assign start_d = addr_dcache_mem[offset_width+2:2];
    assign start_w = start_q;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)       start_q <= '0;
        else if (accept) start_q <= start_d;
    end
`else
    assign start_d = '0;
    assign start_w = '0;
`endif

    // The refill ends when the next word would wrap back onto the starting word.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            strb_q <= '0;
            line_q <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    addr_q <= addr_dcache_mem[ADDR_W-1:2];
                    data_q <= dout_dcache_mem;
                    strb_q <= strb_d;
                    cnt    <= start_d;
                    state  <= dcache_mem_wr ? WR_ISSUE : RD_ISSUE;
                end
                RD_ISSUE: if (bk_gnt) state <= RD_WAIT;
                RD_WAIT: if (bk_rvalid) begin
                    line_q[cnt] <= bk_rdata;
                    if (cnt_nxt == start_w) begin
                        state <= DONE;
                    end else begin
                        cnt   <= cnt_nxt;
                        state <= RD_ISSUE;
                    end
                end
                WR_ISSUE: if (bk_gnt) state <= DONE;
                DONE: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign mem_dcache_addrOK = accept;
    assign mem_dcache_dataOK = (state == DONE);
    assign din_mem_dcache    = line_q;

    always_comb begin
        bk_req   = 1'b0;
        bk_we    = 1'b0;
        bk_addr  = '0;
        bk_wdata = '0;
        bk_wstrb = '0;
        case (state)
            RD_ISSUE: begin
                bk_req  = 1'b1;
                bk_addr = {addr_q[ADDR_W-1:offset_width+3], cnt, 2'b00};
            end
            WR_ISSUE: begin
                bk_req   = 1'b1;
                bk_we    = 1'b1;
                bk_addr  = {addr_q, 2'b00};
                bk_wdata = data_q;
                bk_wstrb = strb_q;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dcache_mem_responder.sv
// Bench for dcache_mem_responder: vector table of reads/writes, backing-port model with an expectation queue.
module tb_dcache_mem_responder;
    logic         clk, rstn;
    logic [31:0]  addr_dcache_mem, dout_dcache_mem;
    logic         dcache_mem_req, dcache_mem_wr;
    logic [1:0]   dcache_mem_size;
    logic [3:0]   dcache_mem_wstrb;
    logic         mem_dcache_addrOK, mem_dcache_dataOK;
    logic [255:0] din_mem_dcache;
    logic         bk_req, bk_we, bk_gnt, bk_rvalid;
    logic [31:0]  bk_addr, bk_wdata, bk_rdata;
    logic [3:0]   bk_wstrb;

    dcache_mem_responder dut (
        .clk(clk), .rstn(rstn),
        .addr_dcache_mem(addr_dcache_mem), .dout_dcache_mem(dout_dcache_mem),
        .dcache_mem_req(dcache_mem_req), .dcache_mem_wr(dcache_mem_wr),
        .dcache_mem_size(dcache_mem_size), .dcache_mem_wstrb(dcache_mem_wstrb),
        .mem_dcache_addrOK(mem_dcache_addrOK), .mem_dcache_dataOK(mem_dcache_dataOK),
        .din_mem_dcache(din_mem_dcache),
        .bk_req(bk_req), .bk_we(bk_we), .bk_addr(bk_addr), .bk_wdata(bk_wdata),
        .bk_wstrb(bk_wstrb), .bk_gnt(bk_gnt), .bk_rvalid(bk_rvalid), .bk_rdata(bk_rdata)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bk_exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] data;
        logic [3:0]  exp_strb;
        logic [31:0] base;
    } vec_t;

    bk_exp_t           bk_q[$];
    vec_t              vecs[9];
    logic [7:0][31:0]  exp_line;
    int                checks = 0, failures = 0;
    int                gnt_delay = 1, rv_delay = 2, wait_cnt = 0, rv_cnt = 0;
    int                beats = 0, gnt_cyc = 0, cyc = 0;
    logic [31:0]       rbase = 32'h0, rv_data = 32'h0, held_addr = 32'h0;
    bit                stale = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Backing port: grants after gnt_delay waiting cycles, returns a beat rv_delay cycles after grant.
    initial begin
        bk_exp_t e;
        bk_gnt = 0; bk_rvalid = 0; bk_rdata = 0;
        forever begin
            @(negedge clk);
            bk_gnt = 0; bk_rvalid = 0;
            if (stale) begin
                bk_rvalid = 1; bk_rdata = 32'hDEAD_BEEF; stale = 0;
            end else if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    bk_rvalid = 1; bk_rdata = rv_data; beats++;
                end
            end
            if (!bk_req || !rstn) begin
                wait_cnt = 0;
            end else begin
                if (wait_cnt == 0) held_addr = bk_addr;
                else chk("bk_addr_hold", bk_addr, held_addr);
                if (wait_cnt < gnt_delay) begin
                    wait_cnt++;
                end else begin
                    bk_gnt = 1; wait_cnt = 0; gnt_cyc = cyc;
                    if (bk_q.size() == 0) begin
                        chk("bk_unexpected_req", bk_addr, 32'hFFFF_FFFF);
                    end else begin
                        e = bk_q.pop_front();
                        chk("bk_addr", bk_addr, e.addr);
                        chk("bk_we", bk_we, e.we);
                        if (e.we) begin
                            chk("bk_wdata", bk_wdata, e.wdata);
                            chk("bk_wstrb", bk_wstrb, e.wstrb);
                        end
                    end
                    if (!bk_we) begin
                        rv_cnt  = rv_delay;
                        rv_data = rbase + ((bk_addr >> 2) & 32'h7);
                    end
                end
            end
        end
    end

    // Called just after a falling edge; leaves on a falling edge.
    task automatic run_txn(input vec_t v, input bit keep);
        int start;
        bit ok;
        start = 0;
`ifdef DCACHE_RESP_CRITICAL_FIRST_EN
        start = int'(v.addr[4:2]);
`endif
        if (v.wr) begin
            bk_q.push_back('{addr: {v.addr[31:2], 2'b00}, we: 1'b1, wdata: v.data, wstrb: v.exp_strb});
        end else begin
            rbase = v.base;
            for (int i = 0; i < 8; i++) begin
                int w;
                w = (start + i) % 8;
                bk_q.push_back('{addr: {v.addr[31:5], 5'b0} + 32'(4 * w), we: 1'b0,
                                 wdata: 32'h0, wstrb: 4'h0});
                exp_line[w] = v.base + 32'(w);
            end
        end
        dcache_mem_req = 1; dcache_mem_wr = v.wr; addr_dcache_mem = v.addr;
        dcache_mem_size = v.size; dcache_mem_wstrb = v.wstrb; dout_dcache_mem = v.data;
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            #1;
            if (mem_dcache_addrOK) begin ok = 1; break; end
            @(negedge clk);
        end
        chk("addrOK_seen", ok, 1);
        @(posedge clk); #1;
        if (!keep) dcache_mem_req = 0;
        ok = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (mem_dcache_dataOK) begin ok = 1; break; end
            chk("addrOK_busy", mem_dcache_addrOK, 0);
        end
        chk("dataOK_seen", ok, 1);
        if (ok) begin
            chk("din_line", din_mem_dcache, exp_line);
            chk("bk_drained", bk_q.size(), 0);
            if (v.wr) chk("wr_dataOK_latency", cyc, gnt_cyc + 1);
            @(negedge clk);
            chk("dataOK_pulse", mem_dcache_dataOK, 0);
            chk("addrOK_after_done", mem_dcache_addrOK, keep);
        end
    endtask

    initial begin
        vec_t v;
        rstn = 0; dcache_mem_req = 0; dcache_mem_wr = 0; addr_dcache_mem = 0;
        dout_dcache_mem = 0; dcache_mem_size = 0; dcache_mem_wstrb = 0;
        exp_line = '0;
        //        wr    addr          size  wstrb    data           exp_strb  base
        vecs[0] = '{1'b0, 32'h0000_1234, 2'd2, 4'b0000, 32'h0,         4'b0000, 32'hA000_0000};
        vecs[1] = '{1'b1, 32'h0000_2006, 2'd1, 4'b0000, 32'hBEEF_0000, 4'b1100, 32'h0};
        vecs[2] = '{1'b1, 32'h0000_3003, 2'd0, 4'b0000, 32'h1122_3344, 4'b1000, 32'h0};
        vecs[3] = '{1'b1, 32'h0000_3001, 2'd0, 4'b0000, 32'h5566_7788, 4'b0010, 32'h0};
        vecs[4] = '{1'b1, 32'h0000_4000, 2'd2, 4'b0000, 32'hCAFE_F00D, 4'b1111, 32'h0};
        vecs[5] = '{1'b1, 32'h0000_4004, 2'd1, 4'b0000, 32'h0000_ABCD, 4'b0011, 32'h0};
        vecs[6] = '{1'b1, 32'h0000_5008, 2'd2, 4'b0110, 32'h0BAD_0BAD, 4'b0110, 32'h0};
        vecs[7] = '{1'b0, 32'h00FF_FFFC, 2'd2, 4'b0000, 32'h0,         4'b0000, 32'hB000_0000};
        vecs[8] = '{1'b0, 32'h0000_0000, 2'd2, 4'b0000, 32'h0,         4'b0000, 32'hC000_0000};

        repeat (2) @(negedge clk);
        chk("reset_ctrl_outs", {mem_dcache_addrOK, mem_dcache_dataOK, bk_req, bk_we,
                                bk_addr, bk_wdata, bk_wstrb}, '0);
        chk("reset_din", din_mem_dcache, '0);
        rstn = 1;
        @(negedge clk);

        for (int i = 0; i < 9; i++) run_txn(vecs[i], 0);

        // Request held through a refill is accepted only after dataOK.
        v = vecs[0]; v.base = 32'hD000_0000;
        run_txn(v, 1);
        v.base = 32'hE000_0000;
        run_txn(v, 0);

        // Grant withheld: request/address must hold.
        gnt_delay = 5;
        v = vecs[8]; v.addr = 32'h0000_0710; v.base = 32'h5000_0000;
        run_txn(v, 0);
        gnt_delay = 1;

        // Reset in the middle of a refill after three beats.
        v = vecs[0]; v.base = 32'h6000_0000;
        beats = 0;
        run_partial: begin
            int start;
            start = 0;
`ifdef DCACHE_RESP_CRITICAL_FIRST_EN
            start = int'(v.addr[4:2]);
`endif
            rbase = v.base;
            for (int i = 0; i < 8; i++)
                bk_q.push_back('{addr: {v.addr[31:5], 5'b0} + 32'(4 * ((start + i) % 8)),
                                 we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        end
        dcache_mem_req = 1; dcache_mem_wr = 0; addr_dcache_mem = v.addr;
        #1 chk("partial_addrOK", mem_dcache_addrOK, 1);
        @(posedge clk); #1 dcache_mem_req = 0;
        for (int k = 0; k < 200 && beats < 3; k++) @(posedge clk);
        chk("partial_beats", beats, 3);
        #2 rstn = 0; bk_q.delete(); rv_cnt = 0;
        #1;
        chk("midrst_ctrl_outs", {mem_dcache_addrOK, mem_dcache_dataOK, bk_req, bk_we,
                                 bk_addr, bk_wdata, bk_wstrb}, '0);
        chk("midrst_din", din_mem_dcache, '0);
        @(negedge clk);
        @(posedge clk); #2 rstn = 1; stale = 1;
        repeat (3) @(negedge clk);
        chk("stale_beat_din", din_mem_dcache, '0);
        chk("stale_beat_dataOK", mem_dcache_dataOK, 0);
        exp_line = '0;
        v.base = 32'h7000_0000;
        run_txn(v, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
